clk_div_n: RTL and testbench
============================

// Module: clk_div_n
// PURPOSE
//   Runtime-programmable integer clock divider: clk_out = clk_in / N, N >= 2.
//   Odd N gives exact 50% duty via a negedge stage; even N uses posedge logic only.
//   Divisor reload, start and stop occur only at period boundaries, so the output
//   never glitches. Used for divided display/scan/baud clocks in the lab designs.
// PARAMETERS
//   DIV_W    8  width of divisor input and internal counter (max N = 2**DIV_W-1)
//   DIV_DEF  2  divisor active out of reset (2 <= DIV_DEF <= 2**DIV_W-1)
// PORTS
//   clk_in   in   1      single source clock; all logic on its posedge, plus one negedge flop
//   rst_n    in   1      asynchronous, active-low reset
//   en       in   1      run request; sampled only at the terminal count
//   div      in   DIV_W  requested divisor N; sampled only at the terminal count
//   clk_out  out  1      divided clock
//   tick     out  1      one-clk_in-cycle pulse, high in the cycle clk_out rises
//   div_err  out  1      sticky; set when div < 2 is sampled; cleared only by reset
// BEHAVIOUR
//   Reset (rst_n=0, async): n_act=DIV_DEF, cnt=DIV_DEF-1, run=0, pos_q=0, neg_q=0,
//     clk_out=0, tick=0, div_err=0.
//   Terminal count: TC = (cnt == n_act-1). Only at a TC posedge:
//     run <= en; n_act <= (div<2) ? 2 : div; div_err <= div_err | (div<2).
//   Counter: when run=1 (after TC update) -> cnt <= TC ? 0 : cnt+1.
//     When stopped, cnt is held at n_act-1 so every edge is a TC.
//   H = ceil(n_act/2). pos_q <= run_next & (cnt_next < H), registered on posedge.
//   neg_q <= pos_q on negedge clk_in (CLKDIV_ODD50_EN only).
//   clk_out: n_act even -> pos_q; n_act odd -> pos_q & neg_q (high N/2 cycles).
//   tick <= run_next & (cnt_next == 0); aligned with clk_out rising.
//   Latency: en=1 seen at TC -> clk_out rises on that same posedge (1 clk_in edge).
//   Stop: en=0 at TC -> clk_out stays low from that edge; never truncates a high phase.
//   div changes mid-period are ignored until the next TC; new N applies to the
//     period that starts at that TC (no partial periods).
//   Wrap-around: N = 2**DIV_W-1 is legal; cnt never exceeds n_act-1.
//   Async reset mid-period: all outputs drop immediately; clk_out may truncate (allowed).
// CONFIGURATION
//   CLKDIV_ODD50_EN defined: negedge neg_q present; odd N gives exact 50% duty.
//   CLKDIV_ODD50_EN undefined: no negedge logic; clk_out = pos_q for all N; odd N
//     is high for (N+1)/2 cycles and low for (N-1)/2 cycles. Tick and timing are identical.
// STRUCTURE
//   Shared package clk_div_pkg: DIV_W default, DIV_MIN=2 constant,
//     half-count function ceil(N/2).
//   One sub-module, clk_div_nstage: negedge half-cycle flop with async reset,
//     instantiated only under CLKDIV_ODD50_EN.
//   Rest is flat: TC compare, reload/run registers, counter, output mux.
// TESTING
//   1. Reset, en=1, div=4 -> clk_out period 4 clk_in, high 2; tick every 4th cycle at rise.
//   2. div=5 with CLKDIV_ODD50_EN -> high 2.5, low 2.5 clk_in; without it -> high 3, low 2.
//   3. Running N=4, div->7 mid-period -> current period completes at 4; next period is 7.
//   4. en 1->0 mid-high phase -> high phase completes, clk_out low from next TC;
//      en=1 -> rises at next edge.
//   5. div=0 then div=1 -> behaves as N=2; div_err=1 and stays 1 after div=3 is applied.
//   6. DIV_W=4, div=15 -> period 15; rst_n low mid-high -> clk_out=0 immediately;
//      after release, DIV_DEF applies.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int DIV_MIN   = 2;

  // Number of clk_in cycles the posedge stage stays high in one period of n.
  function automatic int unsigned half_cnt(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_nstage.sv
// Negedge half-cycle delay flop; lets odd divisors reach an exact 50% duty.
module clk_div_nstage (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider, clk_out = clk_in / N (N >= 2).
// Define CLKDIV_ODD50_EN to add the negedge stage that gives odd N an exact 50% duty.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_DEF = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             div_err
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DIV_DEF);

  logic [DIV_W-1:0] n_act, cnt;
  logic [DIV_W-1:0] n_next, cnt_next, h_next;
  logic             run, run_next, tc, div_low, pos_q;

  assign tc      = (cnt == n_act - ONE);
  assign div_low = (div < MIN_N);

  // en/div only take effect at the terminal count, so periods are never cut short.
  always_comb begin
    run_next = run;
    n_next   = n_act;
    if (tc) begin
      run_next = en;
      n_next   = div_low ? MIN_N : div;
    end
    if (!run_next)   cnt_next = n_next - ONE;
    else if (tc)     cnt_next = '0;
    else             cnt_next = cnt + ONE;
    h_next = DIV_W'(half_cnt(32'(n_next)));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      n_act   <= DEF_N;
      cnt     <= DEF_N - ONE;
      run     <= 1'b0;
      pos_q   <= 1'b0;
      tick    <= 1'b0;
      div_err <= 1'b0;
    end else begin
      n_act <= n_next;
      cnt   <= cnt_next;
      run   <= run_next;
      pos_q <= run_next && (cnt_next < h_next);
      tick  <= run_next && (cnt_next == '0);
      if (tc && div_low) div_err <= 1'b1;
    end
  end

`ifdef CLKDIV_ODD50_EN
  logic neg_q;

  clk_div_nstage u_nstage (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (pos_q),
    .q     (neg_q)
  );

  // Odd N: AND with the half-cycle-late copy trims the high phase to N/2 cycles.
  assign clk_out = n_act[0] ? (pos_q & neg_q) : pos_q;
`else
  assign clk_out = pos_q;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Randomized self-checking bench for clk_div_n against a period-level waveform model.
module tb_clk_div_n;

  localparam int DIV_W   = 4;
  localparam int DIV_DEF = 3;

  logic             clk_in;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             clk_out;
  logic             tick;
  logic             div_err;

  int n_vec = 0;
  int n_err = 0;

  // Expected {clk_out, tick} per half clk_in cycle, one whole period queued at a time.
  logic [1:0] exp_q[$];
  logic       err_m;
  bit         next_is_pos;

  clk_div_n #(.DIV_W(DIV_W), .DIV_DEF(DIV_DEF)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .div     (div),
    .clk_out (clk_out),
    .tick    (tick),
    .div_err (div_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- reference model ----------------
  // s = half-cycle index inside a period of n cycles (0 .. 2n-1).
  function automatic logic exp_high(input int n, input int s);
`ifdef CLKDIV_ODD50_EN
    if (n % 2 == 1) return (s >= 1) && (s <= n);
`endif
    if (n % 2 == 0) return s < n;
    return s <= n;
  endfunction

  function automatic void gen_period();
    int n;
    n = (div < 2) ? 2 : int'(div);
    if (div < 2) err_m = 1'b1;
    if (en) begin
      for (int s = 0; s < 2 * n; s++) exp_q.push_back({exp_high(n, s), (s < 2)});
    end else begin
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
    end
  endfunction

  // Advance to the next sample point (1ns after either clock edge).
  task automatic half(output logic [2:0] obs, output logic [2:0] expv);
    if (next_is_pos) begin
      @(posedge clk_in);
      if (exp_q.size() == 0) gen_period();
      #1;
    end else begin
      @(negedge clk_in);
      #1;
    end
    next_is_pos = !next_is_pos;
    obs  = {clk_out, tick, div_err};
    expv = {exp_q.pop_front(), err_m};
  endtask

  task automatic release_reset();
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    err_m       = 1'b0;
    next_is_pos = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    div   = 4'd4;
    repeat (2) @(posedge clk_in);
    #1;
    n_vec++;
    if (clk_out !== 1'b0) begin n_err++; $display("FAIL reset_clk_out got %b expected 0", clk_out); end
    n_vec++;
    if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b expected 0", tick); end
    n_vec++;
    if (div_err !== 1'b0) begin n_err++; $display("FAIL reset_div_err got %b expected 0", div_err); end
    @(negedge clk_in);
    release_reset();
  endtask

  task automatic test_div4();
    logic [2:0] obs, expv;
    en  = 1'b1;
    div = 4'd4;
    repeat (32) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div4 t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
  endtask

  task automatic test_odd5();
    logic [2:0] obs, expv;
    div = 4'd5;
    repeat (40) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL odd5 t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
  endtask

  task automatic test_div_change();
    logic [2:0] obs, expv;
    div = 4'd4;
    repeat (14) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div_change_pre t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
    div = 4'd7;
    repeat (40) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div_change_post t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
  endtask

  task automatic test_stop_start();
    logic [2:0] obs, expv;
    bit hit;
    div = 4'd4;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL stop_wait t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
      hit = expv[2];
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL stop_wait_high got no high phase expected one within 20 cycles"); end
    en = 1'b0;
    repeat (20) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL stop t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
    en = 1'b1;
    repeat (24) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL restart t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
  endtask

  task automatic test_bad_div();
    logic [2:0] obs, expv;
    div = 4'd0;
    repeat (16) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div0 t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
    div = 4'd1;
    repeat (16) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div1 t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
    div = 4'd3;
    repeat (24) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div3_after_err t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
    n_vec++;
    if (div_err !== 1'b1) begin n_err++; $display("FAIL div_err_sticky got %b expected 1", div_err); end
  endtask

  task automatic test_max_div();
    logic [2:0] obs, expv;
    bit hit;
    en  = 1'b1;
    div = 4'd15;
    repeat (40) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div15 t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL div15_wait t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
      hit = expv[2] && !expv[1];
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL div15_wait_high got no high phase expected one within 40 cycles"); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (clk_out !== 1'b0) begin n_err++; $display("FAIL async_rst_clk_out got %b expected 0", clk_out); end
    n_vec++;
    if (tick !== 1'b0) begin n_err++; $display("FAIL async_rst_tick got %b expected 0", tick); end
    n_vec++;
    if (div_err !== 1'b0) begin n_err++; $display("FAIL async_rst_div_err got %b expected 0", div_err); end
    en = 1'b0;
    release_reset();
    repeat (10) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL post_rst_idle t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
    en = 1'b1;
    repeat (64) begin
      half(obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL post_rst_div15 t=%0t clk/tick/err got %b expected %b", $time, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] obs, expv;
    int len;
    for (int k = 0; k < 80; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      div = DIV_W'($urandom_range(0, 15));
      len = int'($urandom_range(1, 40));
      repeat (len) begin
        half(obs, expv);
        n_vec++;
        if (obs !== expv) begin
          n_err++;
          $display("FAIL random t=%0t en=%b div=%0d clk/tick/err got %b expected %b",
                   $time, en, div, obs, expv);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    next_is_pos = 1'b1;
    err_m       = 1'b0;
    test_reset();
    test_div4();
    test_odd5();
    test_div_change();
    test_stop_start();
    test_bad_div();
    test_max_div();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
